// File: rtl/qadd_share_arb.sv
// qadd_share_arb: round-robin arbiter that shares one wrapping adder among
// NUM_REQ requesters and presents each sum, with its carry and requester tag,
// through a one-entry output register with valid/ready backpressure.
module qadd_share_arb #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int TAG_WIDTH  = 2
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_sum,
    output logic                          out_carry,
    output logic [TAG_WIDTH-1:0]          out_tag,
    output logic                          busy
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_t;

    out_state_t              state_q, state_d;
    logic [DATA_WIDTH-1:0]   sum_q, sum_d;
    logic                    carry_q, carry_d;
    logic [TAG_WIDTH-1:0]    tag_q, tag_d;
    logic [TAG_WIDTH-1:0]    rr_ptr_q, rr_ptr_d;

    logic [DATA_WIDTH-1:0]   a_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0]   b_arr [NUM_REQ];
    logic                    can_accept;
    logic                    grant_found;
    logic [TAG_WIDTH-1:0]    grant_idx;
    logic                    grant_en;
    logic [DATA_WIDTH:0]     full_sum;

    // Unpack the flat operand buses so the granted pair can be picked by index.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign a_arr[gi] = req_a[gi*DATA_WIDTH +: DATA_WIDTH];
            assign b_arr[gi] = req_b[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign out_valid  = (state_q == ST_FULL);
    // The register can take a new result when empty or when it drains this cycle.
    assign can_accept = ~out_valid | out_ready;

    // Round-robin scan starting at rr_ptr_q; index arithmetic wraps naturally
    // because NUM_REQ is a power of two.
    always_comb begin : arb_scan
        logic [TAG_WIDTH-1:0] cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = rr_ptr_q + TAG_WIDTH'(k);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // No handshake may complete while reset is held.
    assign grant_en = grant_found & can_accept & resetn;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = grant_en && (grant_idx == TAG_WIDTH'(gi));
        end
    endgenerate

    // The single shared adder; operands are only looked at through the grant.
    assign full_sum = {1'b0, a_arr[grant_idx]} + {1'b0, b_arr[grant_idx]};

    // Next-state logic for the output register and round-robin pointer.
    always_comb begin
        state_d  = state_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        tag_d    = tag_q;
        rr_ptr_d = rr_ptr_q;
        if (grant_en) begin
            state_d  = ST_FULL;
            sum_d    = full_sum[DATA_WIDTH-1:0];
            carry_d  = full_sum[DATA_WIDTH];
            tag_d    = grant_idx;
            rr_ptr_d = grant_idx + TAG_WIDTH'(1);
        end else if (state_q == ST_FULL && out_ready) begin
            state_d = ST_EMPTY;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= ST_EMPTY;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            tag_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            tag_q    <= tag_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign out_sum   = sum_q;
    assign out_carry = carry_q;
    assign out_tag   = tag_q;
    assign busy      = (|req_valid) | out_valid;

endmodule

// File: tb/tb_qadd_share_arb.sv
// Testbench for qadd_share_arb: directed stimulus, a behavioural model checked
// every cycle, and literal expectations at the key points of each scenario.
module tb_qadd_share_arb;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int TW = 2;

    logic              clk;
    logic              resetn;
    logic [N-1:0]      req_valid;
    logic [N*DW-1:0]   req_a;
    logic [N*DW-1:0]   req_b;
    logic [N-1:0]      req_ready;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_sum;
    logic              out_carry;
    logic [TW-1:0]     out_tag;
    logic              busy;

    int checks = 0;
    int errors = 0;

    // Model state: what the output register and the fairness pointer must hold.
    logic          m_valid = 1'b0;
    logic [DW-1:0] m_sum   = '0;
    logic          m_carry = 1'b0;
    int            m_tag   = 0;
    int            m_ptr   = 0;

    // Requester-rule tracking from the previous edge.
    logic [N-1:0]    prev_pending = '0;
    logic [N*DW-1:0] prev_a = '0;
    logic [N*DW-1:0] prev_b = '0;

    qadd_share_arb #(.NUM_REQ(N), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .out_tag   (out_tag),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Which requester must be granted right now, or -1 for none.
    function automatic int model_grant();
        int g;
        g = -1;
        if (resetn && (!m_valid || out_ready)) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
        end
        return g;
    endfunction

    // Model update at each rising edge, plus the requester stability rule.
    always @(posedge clk) begin
        int g;
        logic [DW:0] s;
        g = model_grant();
        if (resetn) begin
            for (int i = 0; i < N; i++) begin
                if (prev_pending[i]) begin
                    chk("req_hold", {31'd0, req_valid[i]}, 32'd1);
                    chk("req_a_hold", {16'd0, req_a[i*DW +: DW]}, {16'd0, prev_a[i*DW +: DW]});
                    chk("req_b_hold", {16'd0, req_b[i*DW +: DW]}, {16'd0, prev_b[i*DW +: DW]});
                end
            end
        end
        for (int i = 0; i < N; i++) prev_pending[i] = resetn && req_valid[i] && (g != i);
        prev_a = req_a;
        prev_b = req_b;
        if (!resetn) begin
            m_valid = 1'b0; m_sum = '0; m_carry = 1'b0; m_tag = 0; m_ptr = 0;
        end else if (g >= 0) begin
            s = {1'b0, req_a[g*DW +: DW]} + {1'b0, req_b[g*DW +: DW]};
            m_sum   = s[DW-1:0];
            m_carry = s[DW];
            m_tag   = g;
            m_valid = 1'b1;
            m_ptr   = (g + 1) % N;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
    end

    // Compare process: inputs are stable at the falling edge, so both the
    // combinational grant and the registered outputs are checked here.
    always @(negedge clk) begin
        int g;
        logic [N-1:0] exp_ready;
        g = model_grant();
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        chk("req_ready", {28'd0, req_ready}, {28'd0, exp_ready});
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        chk("out_sum", {16'd0, out_sum}, {16'd0, m_sum});
        chk("out_carry", {31'd0, out_carry}, {31'd0, m_carry});
        chk("out_tag", {30'd0, out_tag}, m_tag);
        chk("busy", {31'd0, busy}, {31'd0, (|req_valid) | m_valid});
        if (out_valid && out_ready && resetn)
            $display("result: tag=%0d sum=0x%04h carry=%0d at %0t", out_tag, out_sum, out_carry, $time);
    end

    task automatic set_op(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
        req_a[i*DW +: DW] = a;
        req_b[i*DW +: DW] = b;
    endtask

    // Advance past one rising edge to the input-drive point of the next cycle.
    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    initial begin
        resetn    = 1'b0;
        out_ready = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;

        // Reset held for two cycles.
        tick(); tick();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_sum", {16'd0, out_sum}, 32'd0);
        chk("rst_out_tag", {30'd0, out_tag}, 32'd0);
        resetn = 1'b1;

        // Single request from requester 2.
        set_op(2, 16'h1234, 16'h0101);
        req_valid = 4'b0100;
        #1 chk("single_ready", {28'd0, req_ready}, 32'b0100);
        tick();
        chk("single_valid", {31'd0, out_valid}, 32'd1);
        chk("single_sum", {16'd0, out_sum}, 32'h1335);
        chk("single_tag", {30'd0, out_tag}, 32'd2);
        chk("single_carry", {31'd0, out_carry}, 32'd0);

        // Wrap and carry from requester 0 (pointer at 3, scan wraps to 0).
        set_op(0, 16'hFFFF, 16'h0001);
        req_valid = 4'b0001;
        #1 chk("wrap_ready", {28'd0, req_ready}, 32'b0001);
        tick();
        chk("wrap_sum", {16'd0, out_sum}, 32'h0000);
        chk("wrap_carry", {31'd0, out_carry}, 32'd1);
        chk("wrap_tag", {30'd0, out_tag}, 32'd0);

        // Requester 3 alone brings the pointer back to 0.
        set_op(3, 16'h0010, 16'h0020);
        req_valid = 4'b1000;
        tick();
        chk("r3_tag", {30'd0, out_tag}, 32'd3);
        chk("r3_sum", {16'd0, out_sum}, 32'h0030);

        // Fairness: everyone valid for 8 grants.
        for (int i = 0; i < N; i++) set_op(i, 16'(16'h0100 * (i + 1)), 16'h0003);
        req_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("fair_tag", {30'd0, out_tag}, i % N);
            chk("fair_valid", {31'd0, out_valid}, 32'd1);
        end

        // Backpressure: hold requester 3's result for three cycles.
        out_ready = 1'b0;
        #1 chk("bp_ready0", {28'd0, req_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_tag", {30'd0, out_tag}, 32'd3);
            chk("bp_sum", {16'd0, out_sum}, 32'h0403);
            chk("bp_ready", {28'd0, req_ready}, 32'd0);
        end
        out_ready = 1'b1;
        #1 chk("bp_refill_ready", {28'd0, req_ready}, 32'b0001);
        tick();
        chk("bp_refill_tag", {30'd0, out_tag}, 32'd0);
        chk("bp_refill_sum", {16'd0, out_sum}, 32'h0103);

        // Reset mid-operation with requesters 1 and 3 valid.
        req_valid = 4'b1010;
        resetn    = 1'b0;
        #1 chk("mid_rst_ready", {28'd0, req_ready}, 32'd0);
        tick();
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_sum", {16'd0, out_sum}, 32'd0);
        chk("mid_rst_ready2", {28'd0, req_ready}, 32'd0);
        resetn = 1'b1;
        #1 chk("post_rst_ready", {28'd0, req_ready}, 32'b0010);
        tick();
        chk("post_rst_tag1", {30'd0, out_tag}, 32'd1);
        req_valid = 4'b1000;
        tick();
        chk("post_rst_tag3", {30'd0, out_tag}, 32'd3);

        // Sparse: requester 3 then requester 0, then idle.
        set_op(3, 16'h8000, 16'h8001);
        req_valid = 4'b1000;
        tick();
        chk("sparse_tag3", {30'd0, out_tag}, 32'd3);
        chk("sparse_carry3", {31'd0, out_carry}, 32'd1);
        set_op(0, 16'h0002, 16'h0005);
        req_valid = 4'b0001;
        tick();
        chk("sparse_tag0", {30'd0, out_tag}, 32'd0);
        chk("sparse_sum0", {16'd0, out_sum}, 32'h0007);
        req_valid = 4'b0000;
        #1 chk("sparse_busy_hi", {31'd0, busy}, 32'd1);
        tick();
        chk("sparse_valid_lo", {31'd0, out_valid}, 32'd0);
        chk("sparse_busy_lo", {31'd0, busy}, 32'd0);
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/qadd_share_arb.md
Name: qadd_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one 16-bit wrapping adder (c = a + b mod 2^16) among NUM_REQ requesters in the attention-layer datapath.
- Each requester presents an operand pair with a valid/ready handshake.
- The block grants one request per cycle, registers the sum with the requester's tag and a carry flag, and presents it on a single output port with valid/ready backpressure.

Parameters:
- NUM_REQ, 4, number of requesters sharing the adder (power of two, 2..8).
- DATA_WIDTH, 16, operand and sum width.
- TAG_WIDTH, 2, index width for requesters; equals log2(NUM_REQ).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- resetn  input  1  synchronous, active-low reset.
- req_valid  input  NUM_REQ  per-requester request valid; bit i belongs to requester i.
- req_a  input  NUM_REQ*DATA_WIDTH  operand A, packed; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_b  input  NUM_REQ*DATA_WIDTH  operand B, packed the same way as req_a.
- req_ready  output  NUM_REQ  one-hot (or zero) grant; a handshake completes where valid & ready.
- out_valid  output  1  registered result valid.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  DATA_WIDTH  (a + b) mod 2^DATA_WIDTH.
- out_carry  output  1  carry-out bit of the unsigned addition (bit DATA_WIDTH of the full sum).
- out_tag  output  TAG_WIDTH  index of the requester that produced out_sum.
- busy  output  1  high when any req_valid is high or out_valid is high.

Behaviour:
- Reset (resetn=0 at a rising edge):
  - out_valid=0, out_sum=0, out_carry=0, out_tag=0, round-robin pointer rr_ptr=0.
  - req_ready is forced to 0 combinationally while resetn=0.
  - Reset mid-operation discards any held result; no handshake completes in a reset cycle.
- Output stage: 1-entry register, two states.
  - EMPTY (out_valid=0) -> FULL on a grant.
  - FULL stays FULL if out_ready=0, or if out_ready=1 and a new grant occurs in the same cycle.
  - FULL -> EMPTY if out_ready=1 and there is no grant.
- can_accept = (~out_valid) | out_ready. Same-cycle drain and refill is allowed, so sustained throughput is 1 result per cycle.
- Arbitration, combinational:
  - When can_accept=1, scan req_valid starting at index rr_ptr, ascending with wrap-around at NUM_REQ-1 to 0.
  - The first set bit wins; req_ready has only that bit set.
  - When can_accept=0 or no req_valid is set, req_ready=0.
- On a grant of index g at a rising edge:
  - out_sum <= req_a[g] + req_b[g] truncated to DATA_WIDTH.
  - out_carry <= bit DATA_WIDTH of the full sum.
  - out_tag <= g; out_valid <= 1.
  - rr_ptr <= (g+1) mod NUM_REQ.
- rr_ptr is unchanged when there is no grant.
- Latency: request granted in cycle N -> result visible with out_valid=1 in cycle N+1.
- Requester rules (checked by the bench):
  - Once req_valid[i] is asserted, it and its operands stay stable until the handshake.
  - The block must not depend on this for safety: operands are sampled only at grant.
- Output rule: out_sum, out_carry and out_tag hold stable while out_valid=1 and out_ready=0.
- Boundary cases:
  - All requesters valid continuously -> grants rotate 0,1,2,3,0,...
  - Single requester valid continuously -> granted every cycle (if out_ready=1), regardless of rr_ptr.
  - out_ready=0 with the output FULL -> no grants; rr_ptr frozen.
  - 0xFFFF + 0x0001 -> out_sum=0x0000, out_carry=1.
- The arithmetic is unsigned modular. Signed or fixed-point interpretation is the consumer's responsibility; no saturation.

Test Plan:
- Reset, then a single request: resetn low 2 cycles, then requester 2 asserts a=0x1234, b=0x0101 with out_ready=1 -> req_ready=4'b0100 in that cycle; next cycle out_valid=1, out_sum=0x1335, out_tag=2, out_carry=0.
- Wrap and carry: requester 0, a=0xFFFF, b=0x0001 -> out_sum=0x0000, out_carry=1, out_tag=0.
- Fairness: all 4 requesters valid continuously, out_ready=1, 8 cycles -> out_tag sequence 0,1,2,3,0,1,2,3; one result per cycle; no requester granted twice before all others are granted once.
- Backpressure:
  - Result held with out_ready=0 for 3 cycles -> out_valid, out_sum and out_tag stable; req_ready=0 throughout; rr_ptr unchanged.
  - Then out_ready=1 -> drain and the next grant occur in the same cycle, with the new result one cycle later.
- Reset mid-operation: output FULL and requesters 1 and 3 valid, resetn=0 for one cycle -> out_valid=0, out_sum=0, req_ready=0 in the reset cycle. After release, the grant order starts at requester 1 (rr_ptr=0).
- Sparse requests: requesters 3 then 0 valid in consecutive cycles -> tags 3 then 0 (wrap-around scan); busy falls to 0 one cycle after the last result is accepted.
